cache_miss_fill_ctrl: RTL

- Sits directly downstream of the per-set 4-way tag lookup stage.
- Consumes each lookup result (hard fault flag and hit way index) and keeps 3-bit tree pseudo-LRU state per set.
- On a hard fault it picks the victim way, requests the line from memory, and drives the tag-write strobe and way index back into the lookup stage.
- Stalls the access pipeline while a fill is in flight and during post-reset PLRU initialisation.

---
 rtl/cache_miss_fill_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cache_miss_fill_ctrl.sv
// Miss/fill controller behind a 4-way tag lookup: keeps tree pseudo-LRU per set,
// picks victims on hard faults, runs the memory handshake and the tag-write strobe.
module cache_miss_fill_ctrl #(
  parameter int unsigned SET_BITS = 11,
  parameter int unsigned TAG_HI   = 25
) (
  input  logic                main_clk,
  input  logic                main_rst_n,
  input  logic                in_access_valid,
  input  logic                in_hard_fault,
  input  logic [1:0]          in_hit_way,
  input  logic [30:0]         in_target_address,
  output logic [1:0]          out_way_index,
  output logic                out_do_write,
  output logic                out_stall,
  output logic                mem_req,
  output logic [TAG_HI-4:0]   mem_req_addr,
  input  logic                mem_ack,
  input  logic                mem_fill_done
);

  localparam int unsigned ADDR_W   = 31;
  localparam int unsigned LINE_W   = TAG_HI - 3;
  localparam int unsigned NUM_SETS = 1 << SET_BITS;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_REQ,
    ST_WAIT_FILL,
    ST_TAG_WRITE,
    ST_RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic [SET_BITS-1:0] cnt_q, cnt_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [1:0]          victim_q, victim_d;

  logic                stall_d, req_d, write_d;
  logic [1:0]          way_d;

  logic [2:0]          plru_q [NUM_SETS];
  logic                plru_we;
  logic [SET_BITS-1:0] plru_waddr;
  logic [2:0]          plru_wdata;

  logic [SET_BITS-1:0] acc_set;
  logic [SET_BITS-1:0] fill_set;
  logic                unused_addr_bits;

  assign acc_set          = in_target_address[4 +: SET_BITS];
  assign fill_set         = line_q[SET_BITS-1:0];
  assign mem_req_addr     = line_q;
  assign unused_addr_bits = ^{in_target_address[ADDR_W-1:TAG_HI+1], in_target_address[3:0]};

  // Follow b0 to a pair, then that pair's bit to the way.
  function automatic logic [1:0] plru_victim(input logic [2:0] b);
    return b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
  endfunction

  // Point the tree away from the touched way; the other subtree bit is kept.
  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
    logic [2:0] t;
    t    = b;
    t[0] = ~w[1];
    if (!w[1]) t[1] = ~w[0];
    else       t[2] = ~w[0];
    return t;
  endfunction

  // Next-state, PLRU write port and next registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    victim_d   = victim_q;
    plru_we    = 1'b0;
    plru_waddr = cnt_q;
    plru_wdata = 3'b000;

    case (state_q)
      ST_INIT: begin
        plru_we = 1'b1;
        cnt_d   = cnt_q + SET_BITS'(1);
        if (&cnt_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (in_access_valid) begin
          if (in_hard_fault) begin
            line_d   = in_target_address[TAG_HI:4];
            victim_d = plru_victim(plru_q[acc_set]);
            state_d  = ST_REQ;
          end else begin
            plru_we    = 1'b1;
            plru_waddr = acc_set;
            plru_wdata = plru_touch(plru_q[acc_set], in_hit_way);
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) state_d = ST_WAIT_FILL;
      end
      ST_WAIT_FILL: begin
        if (mem_fill_done) state_d = ST_TAG_WRITE;
      end
      ST_TAG_WRITE: begin
        plru_we    = 1'b1;
        plru_waddr = fill_set;
        plru_wdata = plru_touch(plru_q[fill_set], victim_q);
        state_d    = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    stall_d = (state_d != ST_IDLE);
    req_d   = (state_d == ST_REQ);
    write_d = (state_d == ST_TAG_WRITE);
    way_d   = (state_d == ST_TAG_WRITE || state_d == ST_RELEASE) ? victim_d : 2'b00;
  end

  // Control state and registered outputs.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      line_q        <= '0;
      victim_q      <= 2'b00;
      out_stall     <= 1'b1;
      mem_req       <= 1'b0;
      out_do_write  <= 1'b0;
      out_way_index <= 2'b00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      line_q        <= line_d;
      victim_q      <= victim_d;
      out_stall     <= stall_d;
      mem_req       <= req_d;
      out_do_write  <= write_d;
      out_way_index <= way_d;
    end
  end

  // PLRU storage; contents are defined by the post-reset sweep, not by reset.
  always_ff @(posedge main_clk) begin
    if (plru_we) plru_q[plru_waddr] <= plru_wdata;
  end

endmodule
